// File: rtl/store_buffer.sv
// In-order store write buffer: a circular FIFO drained to data memory over req/ack,
// plus a same-word load hazard flag. Define STORE_BUFFER_MERGE_EN to merge same-word stores into the youngest entry.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 30
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    input  logic [ADDR_W-1:0]          i_word_addr,
    input  logic [31:0]                i_data,
    input  logic [3:0]                 i_mask_n,
    input  logic                       i_trap,
    output logic                       o_ready,
    output logic                       o_mem_req,
    output logic [ADDR_W-1:0]          o_mem_addr,
    output logic [31:0]                o_mem_wdata,
    output logic [3:0]                 o_mem_be,
    input  logic                       i_mem_ack,
    input  logic [ADDR_W-1:0]          i_ld_addr,
    output logic                       o_ld_hit,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t              state_q, state_next;
    logic [CW-1:0]       count_q, count_next;
    logic [PW-1:0]       head_q, tail_q;
    logic [DEPTH-1:0]    valid_q;
    logic                drop_q;

    logic [ADDR_W-1:0]   addr_mem [DEPTH];
    logic [31:0]         data_mem [DEPTH];
    logic [3:0]          mask_mem [DEPTH];

    logic                store_ok;
    logic                accept;
    logic                drop;
    logic                push;
    logic                pop;
    logic                merge;

    // A store is well-formed when it is not trapped and writes at least one byte.
    assign store_ok = i_valid & ~i_trap & (i_mask_n != 4'b1111);
    assign o_ready  = (count_q != FULL_COUNT);
    assign accept   = store_ok & o_ready;
    assign drop     = i_valid & o_ready & ~store_ok;
    assign pop      = (state_q == S_REQ) & i_mem_ack;
    assign push     = accept & ~merge;

`ifdef STORE_BUFFER_MERGE_EN
    logic [PW-1:0] young_idx;
    logic [31:0]   merge_data;

    assign young_idx = tail_q - PW'(1);

    // The head is frozen while it is being offered to memory, so it never merges then.
    assign merge = accept && (count_q != '0)
                && (addr_mem[young_idx] == i_word_addr)
                && !((young_idx == head_q) && (state_q == S_REQ));

    always_comb begin
        merge_data = data_mem[young_idx];
        for (int k = 0; k < 4; k++) begin
            if (!i_mask_n[k]) merge_data[8*k +: 8] = i_data[8*k +: 8];
        end
    end
`else
    assign merge = 1'b0;
`endif

    always_comb begin
        count_next = count_q + CW'(push) - CW'(pop);
    end

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state_q;
        case (state_q)
            S_IDLE:  if (count_next != '0) state_next = S_REQ;
            S_REQ:   if (pop && (count_next == '0)) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_next;
            count_q <= count_next;
            drop_q  <= drop;
            if (pop) begin
                head_q          <= head_q + PW'(1);
                valid_q[head_q] <= 1'b0;
            end
            if (push) begin
                tail_q          <= tail_q + PW'(1);
                valid_q[tail_q] <= 1'b1;
            end
        end
    end

    // NOTE: entry storage is not reset; valid_q alone decides which slots mean anything.
    always_ff @(posedge i_clk) begin
        if (push) begin
            addr_mem[tail_q] <= i_word_addr;
            data_mem[tail_q] <= i_data;
            mask_mem[tail_q] <= i_mask_n;
        end
`ifdef STORE_BUFFER_MERGE_EN
        if (merge) begin
            data_mem[young_idx] <= merge_data;
            mask_mem[young_idx] <= mask_mem[young_idx] & i_mask_n;
        end
`endif
    end

    always_comb begin
        o_ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_mem[i] == i_ld_addr)) o_ld_hit = 1'b1;
        end
    end

    assign o_mem_req   = (state_q == S_REQ);
    assign o_mem_addr  = o_mem_req ? addr_mem[head_q] : '0;
    assign o_mem_wdata = o_mem_req ? data_mem[head_q] : '0;
    assign o_mem_be    = o_mem_req ? ~mask_mem[head_q] : 4'b0000;
    assign o_empty     = (count_q == '0);
    assign o_count     = count_q;
    assign o_drop      = drop_q;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_store_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 30;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_valid = 1'b0;
    logic [ADDR_W-1:0] i_word_addr = '0;
    logic [31:0]       i_data = '0;
    logic [3:0]        i_mask_n = 4'b1111;
    logic              i_trap = 1'b0;
    logic              o_ready;
    logic              o_mem_req;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [3:0]        o_mem_be;
    logic              i_mem_ack = 1'b0;
    logic [ADDR_W-1:0] i_ld_addr = '0;
    logic              o_ld_hit;
    logic              o_empty;
    logic [2:0]        o_count;
    logic              o_drop;

    int checks = 0;
    int failures = 0;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_word_addr(i_word_addr),
        .i_data(i_data), .i_mask_n(i_mask_n), .i_trap(i_trap), .o_ready(o_ready),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_be(o_mem_be), .i_mem_ack(i_mem_ack), .i_ld_addr(i_ld_addr),
        .o_ld_hit(o_ld_hit), .o_empty(o_empty), .o_count(o_count), .o_drop(o_drop)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: a queue of pending stores; memory is requested whenever it is non-empty.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        mask_n;
    } ent_t;

    ent_t mq[$];
    bit   m_drop = 1'b0;

    task automatic model_edge();
        bit   req;
        bit   ready;
        bit   ok;
        bit   do_merge;
        ent_t e;
        req      = (mq.size() != 0);
        ready    = (mq.size() != DEPTH);
        ok       = i_valid && !i_trap && (i_mask_n != 4'b1111);
        do_merge = 1'b0;
        if (i_rst) begin
            mq.delete();
            m_drop = 1'b0;
            return;
        end
        m_drop = i_valid && ready && !ok;
`ifdef STORE_BUFFER_MERGE_EN
        if (ok && ready && (mq.size() > 0) && (mq[$].addr == i_word_addr)
            && ((mq.size() > 1) || !req)) do_merge = 1'b1;
`endif
        if (do_merge) begin
            e = mq[$];
            for (int k = 0; k < 4; k++)
                if (!i_mask_n[k]) e.data[8*k +: 8] = i_data[8*k +: 8];
            e.mask_n = e.mask_n & i_mask_n;
            mq[$] = e;
        end
        if (req && i_mem_ack) void'(mq.pop_front());
        if (ok && ready && !do_merge) begin
            e.addr = i_word_addr;
            e.data = i_data;
            e.mask_n = i_mask_n;
            mq.push_back(e);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_store(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] m);
        i_valid = 1'b1; i_word_addr = a; i_data = d; i_mask_n = m; i_trap = 1'b0;
    endtask

    task automatic idle_inputs();
        i_valid = 1'b0; i_trap = 1'b0; i_mask_n = 4'b1111; i_mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; idle_inputs();
        tick(); tick();
        i_rst = 1'b0;
        checks++; if (o_mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", o_mem_req); end
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", o_empty); end
        checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        checks++; if (o_ready !== 1'b1 || o_drop !== 1'b0) begin failures++; $display("FAIL reset_ready_drop got=%b%b exp=10", o_ready, o_drop); end
        checks++; if ({o_mem_addr, o_mem_wdata, o_mem_be} !== '0) begin failures++; $display("FAIL reset_mem_bus got=%h/%h/%h exp=0", o_mem_addr, o_mem_wdata, o_mem_be); end
        // mid-transaction reset: pending entry discarded, request dropped without an ack
        drive_store(30'h77, 32'h1234_5678, 4'b0000);
        tick(); idle_inputs();
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        checks++; if (o_mem_req !== 1'b0 || o_count !== 3'd0) begin failures++; $display("FAIL midreset got req=%b count=%0d exp req=0 count=0", o_mem_req, o_count); end
    endtask

    task automatic test_single();
        drive_store(30'h10, 32'h0000_00AB, 4'b1110);
        tick(); idle_inputs();
        checks++; if (o_mem_req !== 1'b1) begin failures++; $display("FAIL single_req got=%b exp=1", o_mem_req); end
        checks++; if (o_mem_addr !== 30'h10 || o_mem_be !== 4'b0001 || o_mem_wdata !== 32'h0000_00AB)
            begin failures++; $display("FAIL single_bus got=%h/%b/%h exp=10/0001/000000ab", o_mem_addr, o_mem_be, o_mem_wdata); end
        i_mem_ack = 1'b1; tick(); i_mem_ack = 1'b0;
        checks++; if (o_empty !== 1'b1 || o_mem_req !== 1'b0) begin failures++; $display("FAIL single_drain got empty=%b req=%b exp 1/0", o_empty, o_mem_req); end
    endtask

    task automatic test_fill_wrap();
        logic [31:0] d [5];
        for (int i = 0; i < 5; i++) d[i] = $urandom;
        for (int i = 0; i < 4; i++) begin
            drive_store(30'h100 + 30'(i), d[i], 4'b0000);
            tick();
        end
        idle_inputs();
        checks++; if (o_ready !== 1'b0 || o_count !== 3'd4) begin failures++; $display("FAIL fill_full got ready=%b count=%0d exp 0/4", o_ready, o_count); end
        drive_store(30'h104, d[4], 4'b0000);
        tick();
        checks++; if (o_count !== 3'd4 || o_drop !== 1'b0) begin failures++; $display("FAIL fill_held got count=%0d drop=%b exp 4/0", o_count, o_drop); end
        i_mem_ack = 1'b1; tick(); i_mem_ack = 1'b0;
        checks++; if (o_count !== 3'd3 || o_ready !== 1'b1) begin failures++; $display("FAIL fill_pop got count=%0d ready=%b exp 3/1", o_count, o_ready); end
        tick(); idle_inputs();
        checks++; if (o_count !== 3'd4) begin failures++; $display("FAIL fill_fifth got count=%0d exp=4", o_count); end
        i_mem_ack = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checks++; if (o_mem_addr !== 30'h100 + 30'(i) || o_mem_wdata !== d[i])
                begin failures++; $display("FAIL fill_order%0d got=%h/%h exp=%h/%h", i, o_mem_addr, o_mem_wdata, 30'h100 + 30'(i), d[i]); end
            tick();
        end
        i_mem_ack = 1'b0;
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL fill_empty got=%b exp=1", o_empty); end
    endtask

    task automatic test_drop();
        i_valid = 1'b1; i_trap = 1'b1; i_word_addr = 30'h50; i_data = 32'h0000_BEEF; i_mask_n = 4'b1001;
        tick(); idle_inputs();
        checks++; if (o_drop !== 1'b1 || o_count !== 3'd0 || o_mem_req !== 1'b0)
            begin failures++; $display("FAIL drop_trap got drop=%b count=%0d req=%b exp 1/0/0", o_drop, o_count, o_mem_req); end
        tick();
        checks++; if (o_drop !== 1'b0) begin failures++; $display("FAIL drop_pulse got=%b exp=0", o_drop); end
        drive_store(30'h51, 32'h0, 4'b1111);
        tick(); idle_inputs();
        checks++; if (o_drop !== 1'b1 || o_count !== 3'd0) begin failures++; $display("FAIL drop_nomask got drop=%b count=%0d exp 1/0", o_drop, o_count); end
        tick();
    endtask

    task automatic test_ld_hit();
        drive_store(30'h20, 32'hCAFE_0000, 4'b0011);
        tick(); idle_inputs();
        i_ld_addr = 30'h20; #1;
        checks++; if (o_ld_hit !== 1'b1) begin failures++; $display("FAIL ldhit_match got=%b exp=1", o_ld_hit); end
        i_ld_addr = 30'h21; #1;
        checks++; if (o_ld_hit !== 1'b0) begin failures++; $display("FAIL ldhit_other got=%b exp=0", o_ld_hit); end
        i_ld_addr = 30'h20;
        i_mem_ack = 1'b1; tick(); i_mem_ack = 1'b0;
        checks++; if (o_ld_hit !== 1'b0) begin failures++; $display("FAIL ldhit_popped got=%b exp=0", o_ld_hit); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] seen;
        seen = '0;
        for (int i = 0; i < 3; i++) begin
            drive_store(30'h60 + 30'(i), 32'(i), 4'b0000);
            tick();
        end
        idle_inputs();
        i_mem_ack = 1'b1;
        for (int c = 0; c < 6; c++) begin
            seen[c] = o_mem_req;
            if (o_mem_req) begin
                checks++; if (o_mem_addr !== 30'h60 + 30'(c)) begin failures++; $display("FAIL b2b_addr%0d got=%h exp=%h", c, o_mem_addr, 30'h60 + 30'(c)); end
            end
            tick();
        end
        i_mem_ack = 1'b0;
        checks++; if (seen !== 6'b000111) begin failures++; $display("FAIL b2b_req_pattern got=%b exp=000111", seen); end
    endtask

    task automatic test_merge();
        drive_store(30'h30, 32'h3333_3333, 4'b0000);
        tick();
        drive_store(30'h40, 32'h0000_0011, 4'b1110);
        tick();
        drive_store(30'h40, 32'h0022_0000, 4'b1011);
        tick(); idle_inputs();
`ifdef STORE_BUFFER_MERGE_EN
        checks++; if (o_count !== 3'd2) begin failures++; $display("FAIL merge_count got=%0d exp=2", o_count); end
        i_mem_ack = 1'b1; tick(); i_mem_ack = 1'b0;
        checks++; if (o_mem_addr !== 30'h40 || o_mem_wdata !== 32'h0022_0011 || o_mem_be !== 4'b0101)
            begin failures++; $display("FAIL merge_entry got=%h/%h/%b exp=40/00220011/0101", o_mem_addr, o_mem_wdata, o_mem_be); end
`else
        checks++; if (o_count !== 3'd3) begin failures++; $display("FAIL nomerge_count got=%0d exp=3", o_count); end
        i_mem_ack = 1'b1; tick(); i_mem_ack = 1'b0;
        checks++; if (o_mem_wdata !== 32'h0000_0011 || o_mem_be !== 4'b0001)
            begin failures++; $display("FAIL nomerge_first got=%h/%b exp=00000011/0001", o_mem_wdata, o_mem_be); end
        i_mem_ack = 1'b1; tick(); i_mem_ack = 1'b0;
        checks++; if (o_mem_wdata !== 32'h0022_0000 || o_mem_be !== 4'b0100)
            begin failures++; $display("FAIL nomerge_second got=%h/%b exp=00220000/0100", o_mem_wdata, o_mem_be); end
`endif
        i_mem_ack = 1'b1;
        for (int c = 0; c < 8 && !o_empty; c++) tick();
        i_mem_ack = 1'b0;
        checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL merge_drain got empty=%b exp=1", o_empty); end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] e_addr;
        logic [31:0]       e_data;
        logic [3:0]        e_be;
        bit                e_hit;
        int                rand_fail;
        rand_fail = 0;
        for (int c = 0; c < 400; c++) begin
            i_rst       = ($urandom_range(99) == 0);
            i_valid     = ($urandom_range(1) == 1);
            i_word_addr = 30'($urandom_range(5));
            i_data      = $urandom;
            i_mask_n    = 4'($urandom);
            i_trap      = ($urandom_range(9) == 0);
            i_mem_ack   = ($urandom_range(2) != 0);
            i_ld_addr   = 30'($urandom_range(5));
            #1;
            e_addr = '0; e_data = '0; e_be = '0; e_hit = 1'b0;
            if (mq.size() != 0) begin
                e_addr = mq[0].addr; e_data = mq[0].data; e_be = ~mq[0].mask_n;
            end
            foreach (mq[i]) if (mq[i].addr == i_ld_addr) e_hit = 1'b1;
            checks++;
            if (o_count !== 3'(mq.size()) || o_empty !== (mq.size() == 0) || o_ready !== (mq.size() != DEPTH)
                || o_mem_req !== (mq.size() != 0) || o_drop !== m_drop || o_ld_hit !== e_hit
                || o_mem_addr !== e_addr || o_mem_wdata !== e_data || o_mem_be !== e_be) begin
                failures++;
                rand_fail++;
                if (rand_fail <= 10)
                    $display("FAIL random_cycle%0d got cnt=%0d req=%b drop=%b hit=%b bus=%h/%h/%b exp cnt=%0d drop=%b hit=%b bus=%h/%h/%b",
                             c, o_count, o_mem_req, o_drop, o_ld_hit, o_mem_addr, o_mem_wdata, o_mem_be,
                             mq.size(), m_drop, e_hit, e_addr, e_data, e_be);
            end
            tick();
        end
        i_rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_wrap();
        test_drop();
        test_ld_hit();
        test_back_to_back();
        test_merge();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
